// File: rtl/conv_encoder_framer.sv
// ============================================================================
// Module   : conv_encoder_framer
// Purpose  : Rate-1/2 K=3 convolutional encoder (G0=111, G1=101) fed by a bit
//            FIFO, framing FRAME_LEN data bits plus two zero tail bits.
//            Optional macro CHAN_ERR_EN adds LFSR-driven channel errors on sym[0].
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_encoder_framer #(
    parameter int FRAME_LEN = 32,
    parameter int FIFO_AW   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               din,
    input  logic               din_valid,
    output logic               din_ready,
    input  logic               enc_en,
    input  logic [7:0]         err_thresh,
    output logic [1:0]         sym,
    output logic               sym_valid,
    output logic               sop,
    output logic               eop,
    output logic [FIFO_AW:0]   fifo_level,
    output logic               underflow
);

    localparam int                 c_depth     = 2 ** FIFO_AW;
    localparam int                 c_cnt_w     = $clog2(FRAME_LEN) + 1;
    localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_last  = c_cnt_w'(FRAME_LEN);
    localparam logic [FIFO_AW-1:0] c_ptr_one   = FIFO_AW'(1);
    localparam logic [FIFO_AW:0]   c_lvl_one   = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW:0]   c_lvl_full  = (FIFO_AW + 1)'(c_depth);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_TAIL = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Bit FIFO
    // ------------------------------------------------------------------------
    logic               r_mem [c_depth];
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [FIFO_AW:0]   r_level;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_head;

    assign w_full  = (r_level == c_lvl_full);
    assign w_empty = (r_level == '0);
    assign w_push  = din_valid & ~w_full;
    assign w_head  = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + c_lvl_one;
                2'b01:   r_level <= r_level - c_lvl_one;
                default: r_level <= r_level;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Framing control and encoder datapath
    // ------------------------------------------------------------------------
    state_t             r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_tail;
    logic [1:0]         r_sr;        // {s1, s2}
    logic [1:0]         r_sym;
    logic               r_sym_valid;
    logic               r_sop;
    logic               r_eop;
    logic               r_underflow;
    logic               w_start;
    logic               w_u;
    logic               w_valid_nxt;
    logic               w_g0;
    logic               w_g1;
    logic               w_flip;

    // Blocking the start while eop is on the output guarantees one idle symbol
    // between frames.
    always_comb begin
        w_start     = 1'b0;
        w_pop       = 1'b0;
        w_u         = 1'b0;
        w_valid_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_start     = enc_en & ~w_empty & ~r_eop;
                w_pop       = w_start;
                w_u         = w_start & w_head;
                w_valid_nxt = w_start;
            end
            S_DATA: begin
                w_pop       = ~w_empty;
                w_u         = ~w_empty & w_head;
                w_valid_nxt = 1'b1;
            end
            S_TAIL: begin
                w_valid_nxt = 1'b1;
            end
            default: begin
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    assign w_g0 = w_u ^ r_sr[1] ^ r_sr[0];
    assign w_g1 = w_u ^ r_sr[0];

`ifdef CHAN_ERR_EN
    logic [15:0] r_lfsr;

    // One LFSR value per valid symbol: the value present while a symbol is
    // being registered decides that symbol's flip.
    assign w_flip = w_valid_nxt & (r_lfsr[7:0] < err_thresh);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lfsr <= 16'hACE1;
        end else if (w_valid_nxt) begin
            r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
        end
    end
`else
    logic w_unused_thresh;
    assign w_unused_thresh = ^err_thresh;
    assign w_flip          = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_tail      <= 1'b0;
            r_sr        <= 2'b00;
            r_sym       <= 2'b00;
            r_sym_valid <= 1'b0;
            r_sop       <= 1'b0;
            r_eop       <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_sym_valid <= w_valid_nxt;
            r_sym       <= w_valid_nxt ? {w_g0, w_g1 ^ w_flip} : 2'b00;
            r_sop       <= 1'b0;
            r_eop       <= 1'b0;
            if (w_valid_nxt) begin
                r_sr <= {w_u, r_sr[1]};
            end
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_sop   <= 1'b1;
                        r_cnt   <= c_cnt_one;
                        r_tail  <= 1'b0;
                        r_state <= (FRAME_LEN == 1) ? S_TAIL : S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_empty) begin
                        r_underflow <= 1'b1;
                    end
                    r_cnt <= r_cnt + c_cnt_one;
                    if ((r_cnt + c_cnt_one) == c_cnt_last) begin
                        r_state <= S_TAIL;
                    end
                end
                S_TAIL: begin
                    r_tail <= 1'b1;
                    if (r_tail) begin
                        r_eop   <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign din_ready  = ~w_full;
    assign fifo_level = r_level;
    assign sym        = r_sym;
    assign sym_valid  = r_sym_valid;
    assign sop        = r_sop;
    assign eop        = r_eop;
    assign underflow  = r_underflow;

endmodule

`default_nettype wire

// File: tb/tb_conv_encoder_framer.sv
// ============================================================================
// Module   : tb_conv_encoder_framer
// Purpose  : Self-checking bench for conv_encoder_framer against a queue-based
//            framing/convolution reference model (FRAME_LEN = 4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_conv_encoder_framer;

    localparam int FL    = 4;
    localparam int AW    = 4;
    localparam int DEPTH = 2 ** AW;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          din = 1'b0;
    logic          din_valid = 1'b0;
    logic          din_ready;
    logic          enc_en = 1'b0;
    logic [7:0]    err_thresh = 8'd0;
    logic [1:0]    sym;
    logic          sym_valid;
    logic          sop;
    logic          eop;
    logic [AW:0]   fifo_level;
    logic          underflow;

    conv_encoder_framer #(
        .FRAME_LEN (FL),
        .FIFO_AW   (AW)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .enc_en     (enc_en),
        .err_thresh (err_thresh),
        .sym        (sym),
        .sym_valid  (sym_valid),
        .sop        (sop),
        .eop        (eop),
        .fifo_level (fifo_level),
        .underflow  (underflow)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit          m_q[$];      // FIFO contents
    bit          m_hist[$];   // bits of the current frame, oldest first
    int          m_pos;       // symbol index within frame, -1 when idle
    bit          m_last_eop;
    bit          m_under;
    logic [15:0] m_lfsr;
    logic [1:0]  e_sym;
    bit          e_val, e_sop, e_eop;

    bit          lb_en;
    bit          lb_log[$];   // accepted bits, for loopback
    logic [1:0]  obs_q[$];

    task automatic model_reset();
        m_q.delete();
        m_hist.delete();
        m_pos      = -1;
        m_last_eop = 1'b0;
        m_under    = 1'b0;
        m_lfsr     = 16'hACE1;
        e_sym      = 2'b00;
        e_val      = 1'b0;
        e_sop      = 1'b0;
        e_eop      = 1'b0;
    endtask

    task automatic model_step(input bit d, input bit dv, input bit en, input logic [7:0] thr);
        bit accept, take, u, b1, b2;
        int k;
        accept = dv && (m_q.size() < DEPTH);
        take   = 1'b0;
        u      = 1'b0;
        e_sop  = 1'b0;
        e_eop  = 1'b0;
        if (m_pos < 0) begin
            if (en && m_q.size() > 0 && !m_last_eop) begin
                take  = 1'b1;
                e_sop = 1'b1;
                m_hist.delete();
                u     = m_q.pop_front();
                m_pos = 0;
            end
        end else begin
            take = 1'b1;
            if (m_pos < FL) begin
                if (m_q.size() > 0) u = m_q.pop_front();
                else m_under = 1'b1;
            end
            e_eop = (m_pos == FL + 1);
        end
        if (take) begin
            m_hist.push_back(u);
            k     = m_hist.size() - 1;
            b1    = (k >= 1) ? m_hist[k-1] : 1'b0;
            b2    = (k >= 2) ? m_hist[k-2] : 1'b0;
            e_sym = {u ^ b1 ^ b2, u ^ b2};
`ifdef CHAN_ERR_EN
            if (m_lfsr[7:0] < thr) e_sym[0] = ~e_sym[0];
            m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
`endif
            m_pos = e_eop ? -1 : m_pos + 1;
        end else begin
            e_sym = 2'b00;
        end
        e_val      = take;
        m_last_eop = e_eop;
        if (accept) begin
            m_q.push_back(d);
            if (lb_en) lb_log.push_back(d);
        end
    endtask

    // ---------------- loopback / framing observers ----------------
    logic [1:0] dec_st;
    int         dec_k, fr_cnt, gap_cnt;
    bit         seen_eop;

    task automatic observe();
        bit u, exp_u;
        if (sym_valid) begin
            obs_q.push_back(sym);
            if (sop) begin
                if (lb_en && seen_eop) check_eq("gap", gap_cnt, 1);
                dec_st = 2'b00;
                dec_k  = 0;
                fr_cnt = 0;
            end
            fr_cnt++;
            u      = sym[0] ^ dec_st[0];
            dec_st = {u, dec_st[1]};
            if (lb_en && dec_k < FL) begin
                exp_u = (lb_log.size() > 0) ? lb_log.pop_front() : ~u;
                check_eq("loopback", u, exp_u);
            end
            dec_k++;
            if (eop) begin
                if (lb_en) check_eq("frame_len", fr_cnt, FL + 2);
                seen_eop = 1'b1;
                gap_cnt  = 0;
            end
        end else begin
            gap_cnt++;
        end
    endtask

    task automatic cycle(input bit d, input bit dv, input bit en, input logic [7:0] thr);
        din        = d;
        din_valid  = dv;
        enc_en     = en;
        err_thresh = thr;
        @(posedge clk);
        model_step(d, dv, en, thr);
        #1;
        check_eq("sym", sym, e_sym);
        check_eq("ctl", {sym_valid, sop, eop, underflow}, {e_val, e_sop, e_eop, m_under});
        check_eq("level", fifo_level, m_q.size());
        check_eq("ready", din_ready, m_q.size() < DEPTH);
        observe();
    endtask

    // Reset asserted mid-cycle, outputs checked while held.
    task automatic do_reset();
        reset     = 1'b0;
        din_valid = 1'b0;
        enc_en    = 1'b0;
        #3;
        check_eq("rst_sym", sym, 2'b00);
        check_eq("rst_ctl", {sym_valid, sop, eop, underflow}, 4'b0000);
        check_eq("rst_level", fifo_level, 0);
        check_eq("rst_ready", din_ready, 1'b1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
        obs_q.delete();
        lb_log.delete();
        seen_eop = 1'b0;
        gap_cnt  = 0;
        fr_cnt   = 0;
        dec_k    = 0;
        dec_st   = 2'b00;
    endtask

    logic [1:0] gold_a [6] = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};
    logic [1:0] gold_u [6] = '{2'b11, 2'b01, 2'b01, 2'b11, 2'b00, 2'b00};
    bit         pat_a  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};

    initial begin
        logic [7:0] thr;
        lb_en = 1'b0;
        do_reset();

        // golden frame 1,0,1,1
        for (int i = 0; i < 4; i++) cycle(pat_a[i], 1'b1, 1'b0, 8'd0);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 1'b1, 8'd0);
        check_eq("gold_n", obs_q.size(), 6);
        for (int i = 0; i < 6; i++)
            if (i < obs_q.size()) check_eq($sformatf("gold%0d", i), obs_q[i], gold_a[i]);

        // underflow: only two bits available
        do_reset();
        for (int i = 0; i < 2; i++) cycle(1'b1, 1'b1, 1'b0, 8'd0);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 1'b1, 8'd0);
        check_eq("under_n", obs_q.size(), 6);
        for (int i = 0; i < 6; i++)
            if (i < obs_q.size()) check_eq($sformatf("under%0d", i), obs_q[i], gold_u[i]);
        check_eq("under_sticky", underflow, 1'b1);

        // FIFO full, then drain with and without pushes
        do_reset();
        for (int i = 0; i < 17; i++) cycle(1'($urandom), 1'b1, 1'b0, 8'd0);
        check_eq("full_level", fifo_level, DEPTH);
        check_eq("full_ready", din_ready, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, 8'd0);
        for (int i = 0; i < 3; i++) cycle(1'($urandom), 1'b1, 1'b1, 8'd0);
        for (int i = 0; i < 30; i++) cycle(1'b0, 1'b0, 1'b1, 8'd0);

        // back-to-back frames with continuous pushes and loopback decode
        do_reset();
        lb_en = 1'b1;
        for (int i = 0; i < 200; i++) cycle(1'($urandom), 1'b1, 1'b1, 8'd0);
        lb_en = 1'b0;

        // randomized traffic, reset dropped mid-frame between segments
        for (int seg = 0; seg < 4; seg++) begin
            thr = (seg == 0) ? 8'd0 : (seg == 1) ? 8'd255 : 8'($urandom);
            do_reset();
            for (int i = 0; i < 150 + seg * 7; i++)
                cycle(1'($urandom), ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 8), thr);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
